// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline front end.
// Fetch FSM states, the IF/ID bundle and small address helpers.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        KILL  = 2'd1,
        BUF   = 2'd2
    } fetch_state_t;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    function automatic if_id_t if_id_bubble(input logic [31:0] nop);
        if_id_t b;
        b.instr    = nop;
        b.pc_plus4 = 32'h0;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
// Bubble has priority over load; with neither the register holds.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = mips_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load_i,
    input  logic   bubble_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t q_q;
    if_id_t q_d;

    // Select bubble, new bundle or hold.
    always_comb begin
        q_d = q_q;
        if (bubble_i) begin
            q_d = if_id_bubble(NOP_WORD);
        end else if (load_i) begin
            q_d = d_i;
        end
    end

    // Register; reset leaves a bubble in ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= if_id_bubble(NOP_WORD);
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, next-PC select, imem handshake, IF/ID register.
// Variable imem latency is hidden by bubbles; the stage never stalls ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_enable,
    input  logic        flush_if_id,
    input  logic        pcsrc,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] pc_plus4_D,
    output logic        valid_D
);

    import mips_pkg::fetch_state_t;
    import mips_pkg::FETCH;
    import mips_pkg::KILL;
    import mips_pkg::BUF;
    import mips_pkg::if_id_t;
    import mips_pkg::PC_STEP;
    import mips_pkg::word_align;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic [31:0]  buf_pc4_q, buf_pc4_d;
    logic         req_q, req_d;

    logic         redirect;
    logic         stall;
    logic         accept;
    logic [31:0]  target;
    logic [31:0]  pc_inc;

    logic         ifid_load;
    logic         ifid_bubble;
    if_id_t       ifid_d;
    if_id_t       ifid_q;

    // Hazard-unit decode: redirect beats stall beats plain flush.
    always_comb begin
        redirect = pcsrc | jump;
        stall    = ~pc_enable;
        accept   = imem_ready & req_q;
        target   = word_align(pcsrc ? branch_target : jump_target);
        pc_inc   = pc_q + PC_STEP;
    end

    // Next-state, next-PC and IF/ID control for the fetch FSM.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        tgt_d          = tgt_q;
        buf_instr_d    = buf_instr_q;
        buf_pc4_d      = buf_pc4_q;
        ifid_load      = 1'b0;
        ifid_bubble    = 1'b0;
        ifid_d.instr    = imem_rdata;
        ifid_d.pc_plus4 = pc_inc;
        ifid_d.valid    = ~flush_if_id;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    ifid_bubble = 1'b1;
                    // No request in flight right after reset: jump at once.
                    if (accept || !req_q) begin
                        pc_d = target;
                    end else begin
                        tgt_d   = target;
                        state_d = KILL;
                    end
                end else if (stall) begin
                    if (accept) begin
                        buf_instr_d = imem_rdata;
                        buf_pc4_d   = pc_inc;
                        pc_d        = pc_inc;
                        state_d     = BUF;
                    end
                end else if (accept) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_inc;
                end else begin
                    ifid_bubble = 1'b1;
                end
            end

            KILL: begin
                if (redirect) begin
                    tgt_d = target;
                end
                ifid_bubble = redirect | ~stall;
                // The stale response is dropped; refetch from the target.
                if (accept) begin
                    pc_d    = redirect ? target : tgt_q;
                    state_d = FETCH;
                end
            end

            BUF: begin
                if (redirect) begin
                    ifid_bubble = 1'b1;
                    pc_d        = target;
                    state_d     = FETCH;
                end else if (!stall) begin
                    ifid_load       = 1'b1;
                    ifid_d.instr    = buf_instr_q;
                    ifid_d.pc_plus4 = buf_pc4_q;
                    ifid_d.valid    = ~flush_if_id;
                    state_d         = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase

        req_d = (state_d != BUF);
    end

    // FSM, PC and side registers; req comes up one edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= word_align(RESET_PC);
            tgt_q       <= 32'h0;
            buf_instr_q <= 32'h0;
            buf_pc4_q   <= 32'h0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
            req_q       <= req_d;
        end
    end

    if_id_reg #(
        .NOP_WORD (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst      (reset),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .d_i      (ifid_d),
        .q_o      (ifid_q)
    );

    assign imem_req   = req_q;
    assign imem_addr  = word_align(pc_q);
    assign instr_D    = ifid_q.instr;
    assign pc_plus4_D = ifid_q.pc_plus4;
    assign valid_D    = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        pc_enable;
    logic        flush_if_id;
    logic        pcsrc;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_D;
    logic [31:0] pc_plus4_D;
    logic        valid_D;

    logic        req2;
    logic [31:0] addr2;
    logic [31:0] instr2;
    logic [31:0] pc4_2;
    logic        valid2;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    fetch_stage #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_enable     (pc_enable),
        .flush_if_id   (flush_if_id),
        .pcsrc         (pcsrc),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr_D       (instr_D),
        .pc_plus4_D    (pc_plus4_D),
        .valid_D       (valid_D)
    );

    fetch_stage #(
        .RESET_PC  (32'hFFFF_FFFC),
        .NOP_INSTR (NOP)
    ) dut_wrap (
        .clk           (clk),
        .reset         (reset),
        .pc_enable     (1'b1),
        .flush_if_id   (1'b0),
        .pcsrc         (1'b0),
        .branch_target (32'h0),
        .jump          (1'b0),
        .jump_target   (32'h0),
        .imem_req      (req2),
        .imem_addr     (addr2),
        .imem_ready    (1'b1),
        .imem_rdata    (32'h2409_0007),
        .instr_D       (instr2),
        .pc_plus4_D    (pc4_2),
        .valid_D       (valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: program counter, one pending redirect target,
    // a one-deep holding queue for a word fetched under stall, and
    // the expected ID-stage contents.
    logic [31:0] m_pc;
    logic [31:0] m_ktgt;
    bit          m_req;
    bit          m_kill;
    logic [63:0] m_bufq[$];
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    bit          m_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2008_0005 ^ {a[15:0], 16'h0000};
    endfunction

    task automatic id_bubble();
        m_instr = NOP;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_pc   = RST_PC;
        m_ktgt = 32'h0;
        m_req  = 1'b0;
        m_kill = 1'b0;
        m_bufq.delete();
        id_bubble();
    endtask

    task automatic model_step();
        bit          redir;
        bit          acc;
        logic [31:0] tgt;
        logic [63:0] w;
        if (reset) begin
            model_reset();
            return;
        end
        redir = pcsrc | jump;
        tgt   = (pcsrc ? branch_target : jump_target) & 32'hFFFF_FFFC;
        acc   = m_req && imem_ready;
        if (m_bufq.size() != 0) begin
            if (redir) begin
                m_bufq.delete();
                m_pc = tgt;
                id_bubble();
            end else if (pc_enable) begin
                w = m_bufq.pop_front();
                m_instr = w[63:32];
                m_pc4   = w[31:0];
                m_valid = !flush_if_id;
            end
        end else if (m_kill) begin
            if (redir) m_ktgt = tgt;
            if (redir || pc_enable) id_bubble();
            if (acc) begin
                m_pc   = m_ktgt;
                m_kill = 1'b0;
            end
        end else if (redir) begin
            id_bubble();
            if (acc || !m_req) begin
                m_pc = tgt;
            end else begin
                m_kill = 1'b1;
                m_ktgt = tgt;
            end
        end else if (!pc_enable) begin
            if (acc) begin
                m_bufq.push_back({imem_rdata, m_pc + 32'd4});
                m_pc = m_pc + 32'd4;
            end
        end else if (acc) begin
            m_instr = imem_rdata;
            m_pc4   = m_pc + 32'd4;
            m_valid = !flush_if_id;
            m_pc    = m_pc + 32'd4;
        end else begin
            id_bubble();
        end
        m_req = (m_bufq.size() == 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, let the edge happen, advance the model.
    task automatic step(input bit pe, input bit fl, input bit ps,
                        input logic [31:0] bt, input bit jp,
                        input logic [31:0] jt, input bit rdy);
        pc_enable     = pe;
        flush_if_id   = fl;
        pcsrc         = ps;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
        imem_ready    = rdy;
        imem_rdata    = mem_word(imem_addr);
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 1);
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("m_req",   {31'h0, imem_req}, {31'h0, m_req});
                chk("m_addr",  imem_addr, m_pc);
                chk("m_instr", instr_D, m_instr);
                chk("m_pc4",   pc_plus4_D, m_pc4);
                chk("m_valid", {31'h0, valid_D}, {31'h0, m_valid});
            end
        end
    end

    initial begin
        reset         = 1'b1;
        pc_enable     = 1'b1;
        flush_if_id   = 1'b0;
        pcsrc         = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        imem_ready    = 1'b0;
        imem_rdata    = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        reset  = 1'b0;
        chk_en = 1'b1;

        // Streaming from reset with a zero-wait memory
        step(1, 0, 0, 0, 0, 0, 1);
        chk("t1_req",    {31'h0, imem_req}, 32'h1);
        chk("t1_addr0",  imem_addr, 32'h0);
        chk("t1_valid0", {31'h0, valid_D}, 32'h0);
        chk("t5_addr0",  addr2, 32'hFFFF_FFFC);
        chk("t5_req",    {31'h0, req2}, 32'h1);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("t1_instr",  instr_D, 32'h2008_0005);
        chk("t1_pc4",    pc_plus4_D, 32'h4);
        chk("t1_valid",  {31'h0, valid_D}, 32'h1);
        chk("t1_addr4",  imem_addr, 32'h4);
        chk("t5_addr1",  addr2, 32'h0);
        chk("t5_pc4",    pc4_2, 32'h0);
        chk("t5_valid",  {31'h0, valid2}, 32'h1);
        chk("t5_instr",  instr2, 32'h2409_0007);

        // Load-use stall with a word arriving: buffered, then released
        step(1, 0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 1);
        chk("t2_req",    {31'h0, imem_req}, 32'h0);
        chk("t2_hold",   pc_plus4_D, 32'h8);
        chk("t2_hinstr", instr_D, 32'h200C_0005);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("t2_binstr", instr_D, 32'h2000_0005);
        chk("t2_bpc4",   pc_plus4_D, 32'hC);
        chk("t2_reqon",  {31'h0, imem_req}, 32'h1);
        chk("t2_addr",   imem_addr, 32'hC);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("t2_next",   pc_plus4_D, 32'h10);

        // Taken branch with zero-wait memory: exactly one bubble
        step(1, 0, 1, 32'h42, 0, 0, 1);
        chk("t3_bubble", {31'h0, valid_D}, 32'h0);
        chk("t3_addr",   imem_addr, 32'h40);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("t3_pc4",    pc_plus4_D, 32'h44);
        chk("t3_instr",  instr_D, 32'h2048_0005);

        // Jump while the memory is slow: stale word must be dropped
        step(1, 0, 0, 0, 1, 32'h100, 0);
        chk("t4_v1",     {31'h0, valid_D}, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t4_v2",     {31'h0, valid_D}, 32'h0);
        chk("t4_held",   imem_addr, 32'h44);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t4_v3",     {31'h0, valid_D}, 32'h0);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("t4_addr",   imem_addr, 32'h100);
        chk("t4_v4",     {31'h0, valid_D}, 32'h0);
        step(1, 0, 0, 0, 0, 0, 1);
        chk("t4_pc4",    pc_plus4_D, 32'h104);

        // Stall without data, then stall into buffer dropped by a branch
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 1);
        step(1, 0, 1, 32'h80, 0, 0, 0);
        chk("x_bufdrop", imem_addr, 32'h80);
        run(2);

        // Slow memory: redirect overwritten, then resolved by a late one
        step(1, 0, 0, 0, 1, 32'h300, 0);
        step(1, 0, 1, 32'h400, 0, 0, 0);
        step(1, 0, 0, 0, 1, 32'h500, 1);
        chk("x_kill_new", imem_addr, 32'h500);
        run(2);

        // Reset asserted while a killed request is outstanding
        step(1, 0, 1, 32'h200, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        #1;
        chk("t6_req",   {31'h0, imem_req}, 32'h0);
        chk("t6_addr",  imem_addr, RST_PC);
        chk("t6_valid", {31'h0, valid_D}, 32'h0);
        chk("t6_instr", instr_D, NOP);
        chk("t6_pc4",   pc_plus4_D, 32'h0);
        #1;
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        reset = 1'b0;
        run(3);
        chk("t6_restart", pc_plus4_D, 32'h8);

        @(negedge clk);
        chk_en = 1'b0;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
